detector_share_arb: RTL
=======================

Name: detector_share_arb

Overview:
- Round-robin controller that shares one serial sequence-detector instance between N requesters.
- On each grant it clears the detector and streams the winner's FRAME_LEN-bit serial frame into it.
- It then waits out the detector's output latency, accumulates det_out, and reports hit status and hit count tagged with the requester id.
- Sits between the requester serial sources and the shared detector: it drives the detector's data and sync-reset inputs and consumes its output.

Parameters:
- N, 4, number of requesters (2..16).
- FRAME_LEN, 8, serial bits per frame (>=1).
- DET_LAT, 2, cycles from a det_in bit to its effect on det_out (>=1).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- req  in  N  per-requester frame request level.
- bit_in  in  N  per-requester serial data; the granted requester presents its next bit every cycle shift=1, LSB first.
- gnt  out  N  one-hot grant, held for the whole frame.
- shift  out  1  high during SHIFT; the granted source advances one bit per high cycle.
- det_in  out  1  serial data to the detector.
- det_rst  out  1  active-high sync clear to the detector.
- det_out  in  1  detector output.
- done  out  1  one-cycle result strobe.
- hit  out  1  valid with done: det_out seen high in the sample window.
- hit_id  out  clog2(N)  valid with done: granted requester index.
- hit_cnt  out  clog2(FRAME_LEN+1)  valid with done: det_out-high cycles in the window.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, gnt=0, shift=0, done=0, hit=0, hit_id=0, hit_cnt=0, det_rst=1, det_in=0.
  - Round-robin pointer = N-1, so requester 0 has top priority first.
- States: IDLE -> CLEAR -> SHIFT -> DRAIN -> REPORT -> IDLE. All outputs except det_in are registered.
- IDLE:
  - det_rst=1.
  - If req!=0, pick the first set bit scanning ptr+1, ptr+2, ... modulo N.
  - Register the winner index gid and gnt=onehot(gid); go to CLEAR.
  - req is sampled only in IDLE.
- CLEAR:
  - 1 cycle, det_rst=1, det_in=0.
  - Bit counter=0, accumulators cleared.
- SHIFT:
  - Exactly FRAME_LEN cycles, shift=1, det_rst=0.
  - det_in = bit_in[gid], combinational mux, valid only in SHIFT; det_in=0 otherwise.
- DRAIN: exactly DET_LAT cycles, det_in=0, det_rst=0.
- Sample window:
  - SHIFT cycles with bit counter >= DET_LAT, plus all DRAIN cycles. That is FRAME_LEN cycles total, aligned to the delayed bits.
  - Each window cycle with det_out=1 sets hit_acc and increments cnt_acc. cnt_acc saturates at FRAME_LEN.
  - det_out outside the window is ignored.
- REPORT:
  - 1 cycle: done=1, hit/hit_id/hit_cnt driven from the accumulators.
  - gnt=0, det_rst=1, ptr=gid; next state IDLE.
  - hit/hit_id/hit_cnt hold their values until the next REPORT.
- Timing for a request seen in IDLE at cycle 0:
  - gnt high cycles 1..FRAME_LEN+DET_LAT+1.
  - done at cycle FRAME_LEN+DET_LAT+2.
  - Minimum spacing between grants: FRAME_LEN+DET_LAT+3 cycles.
- Boundary conditions:
  - req deasserted mid-frame: the frame still completes and reports.
  - New req during a frame: waits for IDLE.
  - req=0 in IDLE: stay idle; ptr unchanged.
  - Single persistent requester: granted back-to-back.
  - Reset mid-frame: immediate abort to reset values; no done.

Test Plan:
1. Assert RST=0 during SHIFT -> same cycle gnt=0000, shift=0, det_in=0, det_rst=1, done=0. After release with req=1111 -> first gnt=0001.
2. N=4, FRAME_LEN=8, DET_LAT=2, detector model = det_in delayed 2 cycles. req=0100 with frame 8'b00101100 -> gnt=0100 for 11 cycles, shift high 8 cycles, done at cycle 12, hit=1, hit_id=2, hit_cnt=3.
3. req=1111 held -> grant order 0001, 0010, 0100, 1000, 0001, each 13 cycles apart.
4. Frame 8'b00000000 -> hit=0, hit_cnt=0. Frame 8'b10000000 (last bit only) -> hit=1, hit_cnt=1, captured in DRAIN.
5. Model forces det_out=1 during CLEAR and the first 2 SHIFT cycles, frame all zeros -> hit=0, hit_cnt=0.
6. req=0010 dropped at SHIFT bit 3, req=1000 raised at the same time -> frame for id 1 completes (done, hit_id=1), then gnt=1000.

Source files
------------

// File: rtl/detector_share_arb_if.sv
// rtl/detector_share_arb_if.sv - requester, detector and result signals of the shared-detector arbiter
interface detector_share_arb_if #(
    parameter int N         = 4,
    parameter int FRAME_LEN = 8
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int HCW = $clog2(FRAME_LEN + 1);

    logic [N-1:0]   req;
    logic [N-1:0]   bit_in;
    logic [N-1:0]   gnt;
    logic           shift;
    logic           det_in;
    logic           det_rst;
    logic           det_out;
    logic           done;
    logic           hit;
    logic [IDW-1:0] hit_id;
    logic [HCW-1:0] hit_cnt;

    modport master (
        input  req, bit_in, det_out,
        output gnt, shift, det_in, det_rst, done, hit, hit_id, hit_cnt
    );

    modport slave (
        output req, bit_in, det_out,
        input  gnt, shift, det_in, det_rst, done, hit, hit_id, hit_cnt
    );
endinterface

// File: rtl/detector_share_arb.sv
// rtl/detector_share_arb.sv - round-robin sharing of one serial sequence detector between N requesters
module detector_share_arb #(
    parameter int N         = 4,
    parameter int FRAME_LEN = 8,
    parameter int DET_LAT   = 2
) (
    input logic                  CLK,
    input logic                  RST,
    detector_share_arb_if.master bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int HCW = $clog2(FRAME_LEN + 1);
    localparam int TW  = $clog2(FRAME_LEN + DET_LAT + 1);
    localparam logic [TW-1:0]  SHIFT_LAST = TW'(FRAME_LEN - 1);
    localparam logic [TW-1:0]  DRAIN_LAST = TW'(FRAME_LEN + DET_LAT - 1);
    localparam logic [TW-1:0]  WIN_START  = TW'(DET_LAT);
    localparam logic [HCW-1:0] CNT_MAX    = HCW'(FRAME_LEN);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

    state_t         state, next_state;
    logic [IDW-1:0] ptr, gid, gid_nxt, pick;
    logic           pick_valid;
    logic [TW-1:0]  tcnt;
    logic           window, win_hit;
    logic           hit_acc, hit_acc_nxt;
    logic [HCW-1:0] cnt_acc, cnt_acc_nxt;
    logic [N-1:0]   gnt_nxt;
    logic           shift_nxt, det_rst_nxt, done_nxt;

    // First requesting index after the last winner, wrapping modulo N.
    always_comb begin
        pick_valid = 1'b0;
        pick       = ptr;
        for (int i = 1; i <= N; i++) begin
            if (!pick_valid && bus.req[(int'(ptr) + i) % N]) begin
                pick_valid = 1'b1;
                pick       = IDW'((int'(ptr) + i) % N);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid)         next_state = CLEAR;
            CLEAR:                           next_state = SHIFT;
            SHIFT:   if (tcnt == SHIFT_LAST) next_state = DRAIN;
            DRAIN:   if (tcnt == DRAIN_LAST) next_state = REPORT;
            REPORT:                          next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Window skips the first DET_LAT shift cycles so it lines up with the delayed bits.
    always_comb begin
        window      = ((state == SHIFT) && (tcnt >= WIN_START)) || (state == DRAIN);
        win_hit     = window && bus.det_out;
        hit_acc_nxt = hit_acc | win_hit;
        cnt_acc_nxt = (win_hit && (cnt_acc != CNT_MAX)) ? cnt_acc + HCW'(1) : cnt_acc;
        gid_nxt     = ((state == IDLE) && pick_valid) ? pick : gid;
        gnt_nxt     = '0;
        if ((next_state == CLEAR) || (next_state == SHIFT) || (next_state == DRAIN))
            gnt_nxt = {{(N-1){1'b0}}, 1'b1} << gid_nxt;
        shift_nxt   = (next_state == SHIFT);
        det_rst_nxt = !((next_state == SHIFT) || (next_state == DRAIN));
        done_nxt    = (next_state == REPORT);
        bus.det_in  = (state == SHIFT) ? bus.bit_in[gid] : 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.gnt     <= '0;
            bus.shift   <= 1'b0;
            bus.det_rst <= 1'b1;
            bus.done    <= 1'b0;
            bus.hit     <= 1'b0;
            bus.hit_id  <= '0;
            bus.hit_cnt <= '0;
            ptr         <= IDW'(N - 1);
            gid         <= '0;
            tcnt        <= '0;
            hit_acc     <= 1'b0;
            cnt_acc     <= '0;
        end else begin
            bus.gnt     <= gnt_nxt;
            bus.shift   <= shift_nxt;
            bus.det_rst <= det_rst_nxt;
            bus.done    <= done_nxt;
            gid         <= gid_nxt;
            if (state == CLEAR) begin
                tcnt    <= '0;
                hit_acc <= 1'b0;
                cnt_acc <= '0;
            end else if ((state == SHIFT) || (state == DRAIN)) begin
                tcnt    <= tcnt + TW'(1);
                hit_acc <= hit_acc_nxt;
                cnt_acc <= cnt_acc_nxt;
            end
            // Results include the final DRAIN sample, so load from the next-values.
            if (next_state == REPORT) begin
                bus.hit     <= hit_acc_nxt;
                bus.hit_cnt <= cnt_acc_nxt;
                bus.hit_id  <= gid;
            end
            if (state == REPORT) ptr <= gid;
        end
    end
endmodule
